// File: rtl/dcache_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dcache_pkg                                                    |
// | Purpose  : Shared widths, FSM state encoding and address-split helpers   |
// |            for the direct-mapped write-back data cache.                  |
// | Contents : ADDR_W, DATA_W, state_e, addr_index(), addr_tag()             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package dcache_pkg;

   localparam int ADDR_W = 12;   // 4-byte word address (byte address [13:2])
   localparam int DATA_W = 64;   // one doubleword per line

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOOKUP    = 2'd1,
      ST_WRITEBACK = 2'd2,
      ST_REFILL    = 2'd3
   } state_e;

   // Word address bit 0 selects the word inside the doubleword and is not
   // part of the line address, so the index starts at bit 1.
   function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                    input int idx_w);
      logic [ADDR_W-1:0] mask;
      mask = (ADDR_W'(1) << idx_w) - ADDR_W'(1);
      return (addr >> 1) & mask;
   endfunction

   function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                  input int idx_w);
      return addr >> (idx_w + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_resp_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dcache_req_if / dcache_mem_if                                 |
// | Purpose  : Bundles for the MEM-stage request port (master = pipeline,    |
// |            slave = cache) and the backing-memory port (master = cache,   |
// |            slave = memory).                                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface dcache_req_if;
   logic [dcache_pkg::ADDR_W-1:0] req_addr;
   logic                          req_valid;
   logic                          req_rw;
   logic [dcache_pkg::DATA_W-1:0] data_write;
   logic [dcache_pkg::DATA_W-1:0] data_read;
   logic                          ready;
   logic                          hit;

   modport master (output req_addr, req_valid, req_rw, data_write,
                   input  data_read, ready, hit);
   modport slave  (input  req_addr, req_valid, req_rw, data_write,
                   output data_read, ready, hit);
endinterface

interface dcache_mem_if;
   logic                          mem_req_valid;
   logic                          mem_req_rw;
   logic [dcache_pkg::ADDR_W-1:0] mem_addr;
   logic [dcache_pkg::DATA_W-1:0] mem_wdata;
   logic [dcache_pkg::DATA_W-1:0] mem_rdata;
   logic                          mem_ready;

   modport master (output mem_req_valid, mem_req_rw, mem_addr, mem_wdata,
                   input  mem_rdata, mem_ready);
   modport slave  (input  mem_req_valid, mem_req_rw, mem_addr, mem_wdata,
                   output mem_rdata, mem_ready);
endinterface
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dcache_array                                                  |
// | Purpose  : Tag / valid / dirty / data storage for the direct-mapped      |
// |            cache. Combinational read port, one synchronous write port.   |
// | Ports    : clk, rst_n          clock, async active-low reset             |
// |            rd_idx -> rd_*      line read (valid, dirty, tag, data)       |
// |            wr_en, wr_fill      write strobe; fill=1 loads tag/data,      |
// |                                sets valid, clears dirty; fill=0 is a     |
// |                                store update (data + dirty)               |
// |            wr_idx/tag/data     write payload                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dcache_array
   import dcache_pkg::*;
#(
   parameter int LINES = 64,
   parameter int IDX_W = $clog2(LINES),
   parameter int TAG_W = ADDR_W - 1 - IDX_W
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_valid,
   output logic              rd_dirty,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic              wr_fill,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [DATA_W-1:0] wr_data
);

   logic [LINES-1:0]  r_valid;
   logic [LINES-1:0]  r_dirty;
   logic [TAG_W-1:0]  r_tag_mem  [LINES];
   logic [DATA_W-1:0] r_data_mem [LINES];

   assign rd_valid = r_valid[rd_idx];
   assign rd_dirty = r_dirty[rd_idx];
   assign rd_tag   = r_tag_mem[rd_idx];
   assign rd_data  = r_data_mem[rd_idx];

   // Only the state bits are reset; tag/data contents are meaningless
   // until the matching valid bit is set by a fill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (wr_en) begin
         if (wr_fill) begin
            r_valid[wr_idx] <= 1'b1;
            r_dirty[wr_idx] <= 1'b0;
         end else begin
            r_dirty[wr_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_data_mem[wr_idx] <= wr_data;
         if (wr_fill) begin
            r_tag_mem[wr_idx] <= wr_tag;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dcache_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dcache_resp                                                   |
// | Purpose  : Direct-mapped write-back D-cache answering the MEM stage.     |
// |            Hits complete one cycle after acceptance; misses write back   |
// |            a dirty victim, refill the line, then re-run the lookup.      |
// | Ports    : clk, rst_n          clock, async active-low reset             |
// |            req  (slave)        pipeline request / response               |
// |            mem  (master)       word-wide backing-memory port             |
// |            hit_cnt, miss_cnt   statistics, only with DCACHE_STATS_EN     |
// | Options  : `define DCACHE_STATS_EN adds the hit/miss counters.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dcache_resp
   import dcache_pkg::*;
#(
   parameter int LINES = 64
)
(
   input  logic                clk,
   input  logic                rst_n,
`ifdef DCACHE_STATS_EN
   output logic [31:0]         hit_cnt,
   output logic [31:0]         miss_cnt,
`endif
   dcache_req_if.slave         req,
   dcache_mem_if.master        mem
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - 1 - IDX_W;

   state_e            r_state, w_state_nxt;
   logic              r_first, w_first_nxt;
   logic [IDX_W-1:0]  r_idx,   w_idx_nxt;
   logic [TAG_W-1:0]  r_tag,   w_tag_nxt;

   logic [IDX_W-1:0]  w_req_idx;
   logic [TAG_W-1:0]  w_req_tag;
   logic [IDX_W-1:0]  w_rd_idx;
   logic              w_line_valid;
   logic              w_line_dirty;
   logic [TAG_W-1:0]  w_line_tag;
   logic [DATA_W-1:0] w_line_data;
   logic              w_lookup;
   logic              w_match;
   logic              w_hit;

   logic              w_wr_en;
   logic              w_wr_fill;
   logic [IDX_W-1:0]  w_wr_idx;
   logic [TAG_W-1:0]  w_wr_tag;
   logic [DATA_W-1:0] w_wr_data;

   assign w_req_idx = IDX_W'(addr_index(req.req_addr, IDX_W));
   assign w_req_tag = TAG_W'(addr_tag(req.req_addr, IDX_W));

   // LOOKUP reads the live request address; the miss states work from the
   // copy captured at acceptance so the memory transaction stays stable even
   // if the requester withdraws.
   assign w_lookup = (r_state == ST_LOOKUP);
   assign w_rd_idx = w_lookup ? w_req_idx : r_idx;
   assign w_match  = w_line_valid && (w_line_tag == w_req_tag);
   assign w_hit    = w_lookup && w_match;

   dcache_array #(.LINES(LINES)) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (w_rd_idx),
      .rd_valid (w_line_valid),
      .rd_dirty (w_line_dirty),
      .rd_tag   (w_line_tag),
      .rd_data  (w_line_data),
      .wr_en    (w_wr_en),
      .wr_fill  (w_wr_fill),
      .wr_idx   (w_wr_idx),
      .wr_tag   (w_wr_tag),
      .wr_data  (w_wr_data)
   );

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_first <= 1'b0;
         r_idx   <= '0;
         r_tag   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_first <= w_first_nxt;
         r_idx   <= w_idx_nxt;
         r_tag   <= w_tag_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_nxt = r_state;
      w_first_nxt = r_first;
      w_idx_nxt   = r_idx;
      w_tag_nxt   = r_tag;
      case (r_state)
         ST_IDLE: begin
            if (req.req_valid) begin
               w_state_nxt = ST_LOOKUP;
               w_first_nxt = 1'b1;
               w_idx_nxt   = w_req_idx;
               w_tag_nxt   = w_req_tag;
            end
         end
         ST_LOOKUP: begin
            if (w_match || !req.req_valid) begin
               // A withdrawn request returning from a refill ends here too.
               w_state_nxt = ST_IDLE;
            end else begin
               w_first_nxt = 1'b0;
               w_state_nxt = (w_line_valid && w_line_dirty) ? ST_WRITEBACK : ST_REFILL;
            end
         end
         ST_WRITEBACK: begin
            if (mem.mem_ready) begin
               w_state_nxt = ST_REFILL;
            end
         end
         ST_REFILL: begin
            if (mem.mem_ready) begin
               w_state_nxt = ST_LOOKUP;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- outputs and array write control ----------------
   always_comb begin
      req.ready         = 1'b0;
      req.hit           = 1'b0;
      req.data_read     = '0;
      mem.mem_req_valid = 1'b0;
      mem.mem_req_rw    = 1'b0;
      mem.mem_addr      = '0;
      mem.mem_wdata     = '0;
      w_wr_en           = 1'b0;
      w_wr_fill         = 1'b0;
      w_wr_idx          = r_idx;
      w_wr_tag          = r_tag;
      w_wr_data         = mem.mem_rdata;
      case (r_state)
         ST_LOOKUP: begin
            req.hit       = w_hit;
            req.ready     = w_hit && req.req_valid;
            // Old line contents are returned even for a store so the
            // requester can merge sub-word writes.
            req.data_read = w_line_data;
            if (w_hit && req.req_valid && req.req_rw) begin
               w_wr_en   = 1'b1;
               w_wr_idx  = w_req_idx;
               w_wr_data = req.data_write;
            end
         end
         ST_WRITEBACK: begin
            mem.mem_req_valid = 1'b1;
            mem.mem_req_rw    = 1'b1;
            mem.mem_addr      = {w_line_tag, r_idx, 1'b0};
            mem.mem_wdata     = w_line_data;
         end
         ST_REFILL: begin
            mem.mem_req_valid = 1'b1;
            mem.mem_addr      = {r_tag, r_idx, 1'b0};
            if (mem.mem_ready) begin
               w_wr_en   = 1'b1;
               w_wr_fill = 1'b1;
            end
         end
         default: ;
      endcase
   end

`ifdef DCACHE_STATS_EN
   // Only the first lookup of a request counts as a hit; the re-lookup after
   // a refill is the tail of a miss.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (w_hit && r_first) begin
            hit_cnt <= hit_cnt + 32'd1;
         end
         if (w_lookup && !w_match) begin
            miss_cnt <= miss_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: doc/dcache_resp.md
# dcache_resp

Direct-mapped, write-back data cache that answers the MEM stage's D-cache request interface: `req_addr`/`req_valid`/`req_rw`/`data_write` in, `data_read`/`ready`/`hit` out. It holds 64 lines of one 64-bit doubleword each. It serves hits in one cycle after acceptance. Misses go to a simple word-wide memory port, with write-back of a dirty victim followed by refill.

## Interface
- `LINES`, 64: number of lines; power of two. Index width `IDX_W = log2(LINES)`.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_addr` in 12: 4-byte word address, equal to byte address [13:2]. Bit 0 is ignored. Index is [IDX_W:1]; tag is [11:IDX_W+1].
- `req_valid` in 1: request present. All request fields are held stable until `ready`.
- `req_rw` in 1: 1 = store doubleword, 0 = load.
- `data_write` in 64: full doubleword to store. The initiator has already merged any sub-word bytes.
- `data_read` out 64: indexed line data.
- `ready` out 1: one-cycle completion pulse.
- `hit` out 1: lookup matched.
- `mem_req_valid` out 1: backing-memory request.
- `mem_req_rw` out 1: 1 = write-back, 0 = refill.
- `mem_addr` out 12: word address, bit 0 = 0.
- `mem_wdata` out 64: victim data.
- `mem_rdata` in 64: refill data, valid while `mem_ready`.
- `mem_ready` in 1: memory completes the current request this cycle.
- `hit_cnt`, `miss_cnt` out 32 each: present only with `DCACHE_STATS_EN`.

## Operation
- Per line: valid bit, dirty bit, tag, 64-bit data.
- **IDLE**: on `req_valid`=1, go to LOOKUP. `first` is set.
- **LOOKUP**: `hit` = valid & tag match, driven combinationally from `req_addr`.
  - Hit: `ready`=1 this cycle. `data_read` = line data, which is the old data for a store so the initiator can merge.
  - Store hit: the data array takes `data_write` and dirty is set at the closing edge.
  - Go to IDLE.
  - Miss: if the victim is valid and dirty, go to WRITEBACK; otherwise go to REFILL. Clear `first`.
- **WRITEBACK**: `mem_req_valid`=1, `mem_req_rw`=1, `mem_addr` = {victim tag, index, 0}, `mem_wdata` = victim data. Hold until `mem_ready`, then go to REFILL.
- **REFILL**: `mem_req_valid`=1, `mem_req_rw`=0, `mem_addr` = {req tag, index, 0}. On `mem_ready`:
  - write `mem_rdata` into the line;
  - set valid, clear dirty, load the tag;
  - go to LOOKUP, which now hits and completes the request. A store is applied there.
- Outside LOOKUP: `hit`=0, `ready`=0, `data_read`=0.
- Outside WRITEBACK/REFILL: `mem_req_valid`=0, `mem_req_rw`=0, `mem_addr`=0, `mem_wdata`=0.
- `req_valid` dropping mid-miss does not abort an outstanding memory transaction. The FSM finishes the transaction, completes the line update, and returns to IDLE without pulsing `ready`.

## Timing
- Reset: state IDLE; all valid and dirty bits 0; every output 0; counters 0. The data and tag arrays are not reset.
- Reset mid-miss: `mem_req_valid` drops asynchronously and the transaction is abandoned.
- Hit latency: `req_valid` sampled at edge T, `ready` high during cycle T+1.
- Clean miss: `ready` = 2 + memory latency cycles after acceptance.
- Dirty miss: adds the write-back latency on top of the clean-miss figure.
- Back-to-back requests: in the cycle after `ready`, the FSM is in IDLE and accepts `req_valid` again. Minimum spacing is 2 cycles per hit.
- Memory handshake: `mem_addr`, `mem_wdata` and `mem_req_rw` are stable while `mem_req_valid`=1. Memory may assert `mem_ready` in the first cycle of the request.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_cnt` increments on each LOOKUP hit with `first`=1.
  - `miss_cnt` increments on each LOOKUP miss.
  - Both wrap at 2^32.
- `DCACHE_STATS_EN` undefined: the counters and the two ports are absent. Cache behaviour is identical.

## Structure
- Package `dcache_pkg`:
  - FSM state enum IDLE/LOOKUP/WRITEBACK/REFILL (2 bits);
  - `ADDR_W`=12, `DATA_W`=64;
  - a function deriving tag and index from `req_addr` given `LINES`.
- Sub-module `dcache_array`:
  - holds the tag, valid, dirty and data storage;
  - combinational read port;
  - one synchronous write port with line-fill and store-update modes.
  - The FSM lives in `dcache_resp`.

## Test plan
- **Cold load miss, clean:** load `req_addr`=0x010, memory returns 0xDEAD_BEEF_0123_4567 after 3 cycles.
  - One REFILL with `mem_addr`=0x010.
  - `ready`+`hit` at cycle 5, `data_read`=0xDEAD_BEEF_0123_4567.
- **Load hit:** repeat the same load.
  - `ready` at T+1, no `mem_req_valid`, `hit_cnt`=1.
- **Store hit then load:** store 0x1111 to 0x010, then load 0x010.
  - The store's `data_read` shows the old value.
  - The load returns 0x1111; the line is dirty.
- **Dirty eviction:** load 0x810, which maps to the same index with a different tag.
  - WRITEBACK with `mem_addr`=0x010, `mem_wdata`=0x1111.
  - Then REFILL with `mem_addr`=0x810; `miss_cnt` increments.
- **Reset during REFILL:** assert `rst_n`=0 in REFILL.
  - `mem_req_valid`=0 immediately.
  - After release, a load to 0x010 misses.
- **Zero-latency memory:** `mem_ready` tied high.
  - A clean miss completes in 3 cycles after acceptance.
